branch_predictor: RTL and testbench

BRANCH_PREDICTOR -- requirements
Module: branch_predictor

---
 rtl/branch_predictor_pkg.sv | 30 +++
 rtl/branch_predictor_sat_counter.sv | 21 ++
 rtl/branch_predictor.sv | 100 ++++++++++
 tb/tb_branch_predictor.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/branch_predictor_pkg.sv
// Shared types and constants for the fetch-stage branch predictor.
// Table behaviour is compiled in only with BRANCH_PREDICT_EN defined.
package branch_predictor_pkg;

   localparam int BP_ENTRIES_DEFAULT = 16;
   // Widest tag, reached at the minimum table size of two entries
   localparam int BP_TAG_W = 29;

   typedef enum logic [1:0] {
      BP_STRONG_NT = 2'b00,
      BP_WEAK_NT   = 2'b01,
      BP_WEAK_T    = 2'b10,
      BP_STRONG_T  = 2'b11
   } bp_state_t;

   typedef struct packed {
      logic                valid;
      logic [BP_TAG_W-1:0] tag;
      logic [31:0]         target;
      bp_state_t           state;
   } bp_entry_t;

   localparam bp_entry_t BP_ENTRY_RST = '{
      valid:  1'b0,
      tag:    '0,
      target: '0,
      state:  BP_WEAK_NT
   };

endpackage

// File: rtl/branch_predictor_sat_counter.sv
// Two-bit saturating counter next-state function.
// Counts up on taken and down on not-taken, clamping at both ends.
module bp_sat_counter
   import branch_predictor_pkg::*;
(
   input  bp_state_t state_i,
   input  logic      taken_i,
   output bp_state_t state_o
);

   always_comb begin
      state_o = state_i;
      unique case (state_i)
         BP_STRONG_NT: state_o = taken_i ? BP_WEAK_NT  : BP_STRONG_NT;
         BP_WEAK_NT:   state_o = taken_i ? BP_WEAK_T   : BP_STRONG_NT;
         BP_WEAK_T:    state_o = taken_i ? BP_STRONG_T : BP_WEAK_NT;
         BP_STRONG_T:  state_o = taken_i ? BP_STRONG_T : BP_WEAK_T;
      endcase
   end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit counters, looked up from the fetch PC.
// Define BRANCH_PREDICT_EN for the table; otherwise static not-taken.
module branch_predictor
   import branch_predictor_pkg::*;
#(
   parameter int BP_ENTRIES = BP_ENTRIES_DEFAULT
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic [31:0] PC_F,
   output logic        Predict_Taken_F,
   output logic [31:0] Predict_Target_F,
   input  logic        Branch_E,
   input  logic        Branch_Taken_E,
   input  logic [31:0] PC_E,
   input  logic [31:0] Branch_Target_E
);

   bp_state_t cnt_cur;
   bp_state_t cnt_nxt;

   bp_sat_counter u_cnt (
      .state_i (cnt_cur),
      .taken_i (Branch_Taken_E),
      .state_o (cnt_nxt)
   );

`ifdef BRANCH_PREDICT_EN

   localparam int IDX_W = $clog2(BP_ENTRIES);

   bp_entry_t           tbl_q [BP_ENTRIES];
   bp_entry_t           ent_d;
   bp_entry_t           f_ent;
   bp_entry_t           e_ent;
   logic                wr_en;
   logic                e_hit;
   logic [IDX_W-1:0]    f_idx;
   logic [IDX_W-1:0]    e_idx;
   logic [BP_TAG_W-1:0] f_tag;
   logic [BP_TAG_W-1:0] e_tag;
   logic                unused_ok;

   assign f_idx = PC_F[IDX_W+1:2];
   assign e_idx = PC_E[IDX_W+1:2];
   assign f_tag = BP_TAG_W'(PC_F[31:IDX_W+2]);
   assign e_tag = BP_TAG_W'(PC_E[31:IDX_W+2]);

   // Lookup reads registered state only: no bypass from execute
   assign f_ent = tbl_q[f_idx];
   assign Predict_Taken_F  = f_ent.valid && (f_ent.tag == f_tag)
                             && f_ent.state[1];
   assign Predict_Target_F = f_ent.target;

   assign e_ent   = tbl_q[e_idx];
   assign e_hit   = e_ent.valid && (e_ent.tag == e_tag);
   assign cnt_cur = e_ent.state;

   always_comb begin
      wr_en = 1'b0;
      ent_d = e_ent;
      if (Branch_E) begin
         if (e_hit) begin
            wr_en       = 1'b1;
            ent_d.state = cnt_nxt;
            if (Branch_Taken_E) ent_d.target = Branch_Target_E;
         end else if (Branch_Taken_E) begin
            wr_en        = 1'b1;
            ent_d.valid  = 1'b1;
            ent_d.tag    = e_tag;
            ent_d.target = Branch_Target_E;
            ent_d.state  = BP_WEAK_T;
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         for (int i = 0; i < BP_ENTRIES; i++) tbl_q[i] <= BP_ENTRY_RST;
      end else if (wr_en) begin
         tbl_q[e_idx] <= ent_d;
      end
   end

   assign unused_ok = ^{PC_F[1:0], PC_E[1:0]};

`else

   logic unused_ok;

   assign cnt_cur          = BP_WEAK_NT;
   assign Predict_Taken_F  = 1'b0;
   assign Predict_Target_F = 32'h0;

   assign unused_ok = ^{CLK, RST, PC_F, Branch_E, PC_E,
                        Branch_Target_E, cnt_nxt, BP_ENTRIES[0]};

`endif

endmodule

// File: tb/tb_branch_predictor.sv
// Directed and random checks of branch_predictor against a table model.
// Expectations follow BRANCH_PREDICT_EN exactly as the design build does.
module tb_branch_predictor;

   localparam int N  = 16;
   localparam int IW = 4;
`ifdef BRANCH_PREDICT_EN
   localparam bit EN = 1'b1;
`else
   localparam bit EN = 1'b0;
`endif

   logic        CLK = 1'b0;
   logic        RST = 1'b0;
   logic [31:0] PC_F = '0;
   logic        Predict_Taken_F;
   logic [31:0] Predict_Target_F;
   logic        Branch_E = 1'b0;
   logic        Branch_Taken_E = 1'b0;
   logic [31:0] PC_E = '0;
   logic [31:0] Branch_Target_E = '0;

   int n_tests = 0;
   int n_fail  = 0;

   bit          m_v   [N];
   int unsigned m_tag [N];
   logic [31:0] m_tgt [N];
   int          m_cnt [N];

   always #5 CLK = ~CLK;

   branch_predictor #(.BP_ENTRIES(N)) dut (
      .CLK              (CLK),
      .RST              (RST),
      .PC_F             (PC_F),
      .Predict_Taken_F  (Predict_Taken_F),
      .Predict_Target_F (Predict_Target_F),
      .Branch_E         (Branch_E),
      .Branch_Taken_E   (Branch_Taken_E),
      .PC_E             (PC_E),
      .Branch_Target_E  (Branch_Target_E)
   );

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got %h exp %h", tag, got, exp);
      end
   endtask

   function automatic int idx_of(input logic [31:0] pc);
      return int'((pc >> 2) % N);
   endfunction

   function automatic int unsigned tag_of(input logic [31:0] pc);
      return pc >> (IW + 2);
   endfunction

   function automatic bit m_hit(input logic [31:0] pc);
      return m_v[idx_of(pc)] && (m_tag[idx_of(pc)] == tag_of(pc));
   endfunction

   task automatic m_reset();
      for (int i = 0; i < N; i++) begin
         m_v[i] = 0; m_tag[i] = 0; m_tgt[i] = '0; m_cnt[i] = 1;
      end
   endtask

   task automatic m_update(input bit rst, input bit be, input bit bt,
                           input logic [31:0] pce, input logic [31:0] tgt);
      int i;
      i = idx_of(pce);
      if (rst) m_reset();
      else if (be) begin
         if (m_hit(pce)) begin
            if (bt) begin
               m_cnt[i] = (m_cnt[i] < 3) ? m_cnt[i] + 1 : 3;
               m_tgt[i] = tgt;
            end else begin
               m_cnt[i] = (m_cnt[i] > 0) ? m_cnt[i] - 1 : 0;
            end
         end else if (bt) begin
            m_v[i] = 1; m_tag[i] = tag_of(pce);
            m_tgt[i] = tgt; m_cnt[i] = 2;
         end
      end
   endtask

   // One cycle: drive, check pre-edge lookup, clock, advance the model
   task automatic step(input string tag, input logic [31:0] pcf,
                       input bit be, input bit bt,
                       input logic [31:0] pce, input logic [31:0] tgt,
                       input bit rst);
      bit exp_t;
      int i;
      PC_F = pcf; Branch_E = be; Branch_Taken_E = bt;
      PC_E = pce; Branch_Target_E = tgt; RST = rst;
      #2;
      i = idx_of(pcf);
      exp_t = EN && m_hit(pcf) && (m_cnt[i] >= 2);
      check({tag, ".taken"}, {31'b0, Predict_Taken_F}, {31'b0, exp_t});
      if (exp_t) check({tag, ".target"}, Predict_Target_F, m_tgt[i]);
      @(posedge CLK);
      m_update(rst, be, bt, pce, tgt);
      @(negedge CLK);
   endtask

   function automatic logic [31:0] rnd_pc();
      logic [31:0] pc;
      if ($urandom_range(0, 7) == 0) pc = $urandom & 32'hFFFF_FFFC;
      else pc = ($urandom_range(0, 3) << 6) | ($urandom_range(0, 15) << 2);
      return pc;
   endfunction

   initial begin
      m_reset();
      @(negedge CLK);
      step("rst_hold", 32'h40, 1, 1, 32'h40, 32'h100, 1);
      step("rst_look", 32'h40, 0, 0, 32'h0, 32'h0, 0);
      step("same_cyc", 32'h40, 1, 1, 32'h40, 32'h100, 0);
      step("alloc", 32'h40, 0, 0, 32'h0, 32'h0, 0);
      step("nt1", 32'h40, 1, 0, 32'h40, 32'h0, 0);
      step("nt2", 32'h40, 1, 0, 32'h40, 32'h0, 0);
      step("nt_look", 32'h40, 1, 0, 32'h40, 32'h0, 0);
      step("nt_sat", 32'h40, 1, 0, 32'h40, 32'h0, 0);
      step("nt_sat2", 32'h40, 0, 0, 32'h0, 32'h0, 0);
      step("t_up", 32'h40, 1, 1, 32'h40, 32'h140, 0);
      step("t_up2", 32'h40, 1, 1, 32'h40, 32'h180, 0);
      step("retrain", 32'h40, 0, 0, 32'h0, 32'h0, 0);
      step("alias_w", 32'h80, 1, 1, 32'h80, 32'h200, 0);
      step("alias_a", 32'h40, 0, 0, 32'h0, 32'h0, 0);
      step("alias_b", 32'h80, 1, 0, 32'h44, 32'h0, 0);
      step("nt_miss", 32'h44, 0, 0, 32'h0, 32'h0, 0);
      step("alias_c", 32'h80, 0, 1, 32'h80, 32'h300, 0);
      step("rst_upd", 32'h80, 1, 1, 32'h80, 32'h400, 1);
      step("rst_empty", 32'h80, 0, 0, 32'h0, 32'h0, 0);
      for (int k = 0; k < 400; k++) begin
         logic [31:0] pce;
         pce = rnd_pc();
         step("rand", ($urandom_range(0, 1) != 0) ? pce : rnd_pc(),
              $urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0,
              pce, $urandom, $urandom_range(0, 99) == 0);
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
